multicycle_control: RTL and testbench

Parametrised multi-cycle control unit for the RV32I core, successor to the single-cycle combinational decoder. It fetches each instruction over a ready-handshaked memory port and latches it into an internal instruction register. It then sequences execute, memory and writeback over several cycles and adds conditional branches. It also traps on illegal encodings and on memory timeouts. It sits between the unified memory interface and the datapath (register file, ALU, immediate generator, PC register).

---
 rtl/multicycle_control.sv | 208 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control: fetches into an IR, then sequences execute/memory/writeback/branch.
// Sticky traps on illegal encodings and on memory requests that outlast MEM_TIMEOUT wait cycles.
module multicycle_control #(
  parameter int ALUOP_W     = 4,
  parameter int IMM_SRC_W   = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          instr,
  input  logic                 mem_ready,
  input  logic                 alu_zero,
  output logic                 mem_req,
  output logic                 pc_inc,
  output logic                 pc_branch,
  output logic [ALUOP_W-1:0]   AluOp,
  output logic                 regWrite,
  output logic [4:0]           rs1,
  output logic [4:0]           rs2,
  output logic [4:0]           rd,
  output logic [IMM_SRC_W-1:0] imm_src,
  output logic                 aluB_src,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 MemToReg,
  output logic                 instr_done,
  output logic                 illegal,
  output logic                 mem_fault
);
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALUWB, S_MEMADDR,
    S_MEMRD, S_MEMWB, S_MEMWR, S_BRANCH, S_TRAP
  } state_t;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_XOR = 4'd2, OP_AND = 4'd3,
                         OP_OR  = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                         OP_SLT = 4'd8, OP_SLTU = 4'd9;
  localparam logic [6:0] OPC_R = 7'b0110011, OPC_I = 7'b0010011, OPC_LOAD = 7'b0000011,
                         OPC_STORE = 7'b0100011, OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_BASE = 7'h00, F7_ALT = 7'h20;
  localparam logic [7:0] TIMEOUT_M1 = 8'(MEM_TIMEOUT - 1);

  state_t      state, state_nx;
  logic [31:0] ir;
  logic [7:0]  wait_cnt;
  logic        illegal_q, fault_q, set_illegal, set_fault;
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic        is_r, arith_ok, br_ok, br_taken, mem_wait, timeout;
  logic [3:0]  arith_op, br_op, alu_op;

  assign opcode = ir[6:0];
  assign f3     = ir[14:12];
  assign f7     = ir[31:25];
  assign is_r   = (opcode == OPC_R);

  // Shared by EXEC_* and ALUWB so the ALU control stays stable through writeback.
  always_comb begin
    arith_op = OP_ADD;
    arith_ok = 1'b1;
    case (f3)
      3'b000: begin
        arith_op = (is_r && f7 == F7_ALT) ? OP_SUB : OP_ADD;
        arith_ok = !is_r || f7 == F7_BASE || f7 == F7_ALT;
      end
      3'b001: begin arith_op = OP_SLL;  arith_ok = (f7 == F7_BASE); end
      3'b010: begin arith_op = OP_SLT;  arith_ok = !is_r || f7 == F7_BASE; end
      3'b011: begin arith_op = OP_SLTU; arith_ok = !is_r || f7 == F7_BASE; end
      3'b100: begin arith_op = OP_XOR;  arith_ok = !is_r || f7 == F7_BASE; end
      3'b101: begin
        arith_op = (f7 == F7_ALT) ? OP_SRA : OP_SRL;
        arith_ok = (f7 == F7_BASE) || (f7 == F7_ALT);
      end
      3'b110: begin arith_op = OP_OR;   arith_ok = !is_r || f7 == F7_BASE; end
      3'b111: begin arith_op = OP_AND;  arith_ok = !is_r || f7 == F7_BASE; end
    endcase
  end

  // EQ/GE/GEU branch when the ALU result is zero; the other three branch on non-zero.
  always_comb begin
    br_op    = OP_SUB;
    br_ok    = 1'b1;
    br_taken = alu_zero ^ (f3[2] ^ f3[0]);
    case (f3[2:1])
      2'b00: br_op = OP_SUB;
      2'b01: br_ok = 1'b0;
      2'b10: br_op = OP_SLT;
      2'b11: br_op = OP_SLTU;
    endcase
  end

  assign mem_wait = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign timeout  = mem_wait && !mem_ready && (wait_cnt == TIMEOUT_M1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      ir        <= '0;
      wait_cnt  <= '0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_FETCH && mem_ready) ir <= instr;
      if (state_nx != state || mem_ready || !mem_wait) wait_cnt <= '0;
      else                                             wait_cnt <= wait_cnt + 8'd1;
      if (set_illegal) illegal_q <= 1'b1;
      if (set_fault)   fault_q   <= 1'b1;
    end
  end

  always_comb begin
    state_nx    = state;
    set_illegal = 1'b0;
    set_fault   = 1'b0;
    case (state)
      S_FETCH: begin
        if (mem_ready)    state_nx = S_DECODE;
        else if (timeout) begin state_nx = S_TRAP; set_fault = 1'b1; end
      end
      S_DECODE: begin
        case (opcode)
          OPC_R:                state_nx = S_EXEC_R;
          OPC_I:                state_nx = S_EXEC_I;
          OPC_LOAD, OPC_STORE:  state_nx = S_MEMADDR;
          OPC_BRANCH:           state_nx = S_BRANCH;
          default: begin state_nx = S_TRAP; set_illegal = 1'b1; end
        endcase
      end
      S_EXEC_R, S_EXEC_I: begin
        if (arith_ok) state_nx = S_ALUWB;
        else begin state_nx = S_TRAP; set_illegal = 1'b1; end
      end
      S_ALUWB: state_nx = S_FETCH;
      S_MEMADDR: begin
        if (f3 != 3'b010)           begin state_nx = S_TRAP; set_illegal = 1'b1; end
        else if (opcode == OPC_LOAD) state_nx = S_MEMRD;
        else                         state_nx = S_MEMWR;
      end
      S_MEMRD: begin
        if (mem_ready)    state_nx = S_MEMWB;
        else if (timeout) begin state_nx = S_TRAP; set_fault = 1'b1; end
      end
      S_MEMWB: state_nx = S_FETCH;
      S_MEMWR: begin
        if (mem_ready)    state_nx = S_FETCH;
        else if (timeout) begin state_nx = S_TRAP; set_fault = 1'b1; end
      end
      S_BRANCH: begin
        if (br_ok) state_nx = S_FETCH;
        else begin state_nx = S_TRAP; set_illegal = 1'b1; end
      end
      S_TRAP:  state_nx = S_TRAP;
      default: state_nx = S_FETCH;
    endcase
  end

  // Everything is forced low while rst is high, including the IR fields and flags.
  always_comb begin
    mem_req    = 1'b0;
    pc_inc     = 1'b0;
    pc_branch  = 1'b0;
    alu_op     = OP_ADD;
    regWrite   = 1'b0;
    imm_src    = '0;
    aluB_src   = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemToReg   = 1'b0;
    instr_done = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin mem_req = 1'b1; pc_inc = mem_ready; end
        S_EXEC_R: alu_op = arith_op;
        S_EXEC_I: begin alu_op = arith_op; aluB_src = 1'b1; end
        S_ALUWB: begin
          alu_op     = arith_op;
          aluB_src   = (opcode == OPC_I);
          regWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMADDR, S_MEMRD, S_MEMWR: begin
          aluB_src = 1'b1;
          imm_src  = (opcode == OPC_STORE) ? IMM_SRC_W'(3'b010) : IMM_SRC_W'(3'b001);
          mem_req  = (state != S_MEMADDR);
          MemRead  = (state == S_MEMRD);
          MemWrite = (state == S_MEMWR);
          instr_done = (state == S_MEMWR) && mem_ready;
        end
        S_MEMWB: begin regWrite = 1'b1; MemToReg = 1'b1; instr_done = 1'b1; end
        S_BRANCH: begin
          imm_src    = IMM_SRC_W'(3'b011);
          alu_op     = br_op;
          pc_branch  = br_ok && br_taken;
          instr_done = br_ok;
        end
        default: ;
      endcase
    end
  end

  assign AluOp     = ALUOP_W'(alu_op);
  assign rs1       = rst ? 5'd0 : ir[19:15];
  assign rs2       = rst ? 5'd0 : ir[24:20];
  assign rd        = rst ? 5'd0 : ir[11:7];
  assign illegal   = illegal_q && !rst;
  assign mem_fault = fault_q && !rst;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed scenarios plus a randomized instruction stream
// checked against an instruction-level model (class, legality, cycle count, effects).
module tb_multicycle_control;
  localparam int ALUOP_W = 4, IMM_SRC_W = 3, MEM_TIMEOUT = 15;

  logic clk = 1'b0, rst = 1'b1, mem_ready = 1'b0, alu_zero = 1'b0;
  logic [31:0] instr = '0;
  logic mem_req, pc_inc, pc_branch, regWrite, aluB_src, MemRead, MemWrite, MemToReg;
  logic instr_done, illegal, mem_fault;
  logic [ALUOP_W-1:0] AluOp;
  logic [4:0] rs1, rs2, rd;
  logic [IMM_SRC_W-1:0] imm_src;
  logic [32:0] outvec;

  multicycle_control #(.ALUOP_W(ALUOP_W), .IMM_SRC_W(IMM_SRC_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .alu_zero(alu_zero),
    .mem_req(mem_req), .pc_inc(pc_inc), .pc_branch(pc_branch), .AluOp(AluOp),
    .regWrite(regWrite), .rs1(rs1), .rs2(rs2), .rd(rd), .imm_src(imm_src),
    .aluB_src(aluB_src), .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
    .instr_done(instr_done), .illegal(illegal), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  assign outvec = {mem_req, pc_inc, pc_branch, AluOp, regWrite, rs1, rs2, rd, imm_src,
                   aluB_src, MemRead, MemWrite, MemToReg, instr_done, illegal, mem_fault};

  int n_chk = 0, n_fail = 0;
  int o_cycles, o_done, o_inc, o_rw, o_rw_cycle, o_mw, o_mr, o_br, o_conflict;
  logic [4:0] o_rw_rd;
  logic [3:0] o_rw_op, o_done_op;
  logic o_rw_m2r, o_illegal, o_hung;

  logic [3:0] base_op [8] = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd2, 4'd6, 4'd4, 4'd3};
  logic [3:0] br_op   [8] = '{4'd1, 4'd1, 4'd0, 4'd0, 4'd8, 4'd8, 4'd9, 4'd9};
  logic       eq_take [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  // Classes: 0=R 1=I 2=load 3=store 4=branch 5=unknown opcode.
  function automatic void model(input logic [31:0] i, input logic z, output int cls,
                                output logic legal, output logic [3:0] op, output logic taken);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = i[14:12]; f7 = i[31:25];
    legal = 1'b1; taken = 1'b0; op = 4'd0; cls = 5;
    case (i[6:0])
      7'h33: begin
        cls = 0; op = base_op[f3];
        if (f7 == 7'h20 && f3 == 3'd0) op = 4'd1;
        else if (f7 == 7'h20 && f3 == 3'd5) op = 4'd7;
        else if (f7 != 7'h00) legal = 1'b0;
      end
      7'h13: begin
        cls = 1; op = base_op[f3];
        if (f3 == 3'd1 && f7 != 7'h00) legal = 1'b0;
        if (f3 == 3'd5) begin
          if (f7 == 7'h20) op = 4'd7;
          else if (f7 != 7'h00) legal = 1'b0;
        end
      end
      7'h03: begin cls = 2; legal = (f3 == 3'd2); end
      7'h23: begin cls = 3; legal = (f3 == 3'd2); end
      7'h63: begin
        cls = 4; legal = (f3 != 3'd2) && (f3 != 3'd3);
        op = br_op[f3]; taken = eq_take[f3] ? z : !z;
      end
      default: legal = 1'b0;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // Runs one instruction from its first FETCH cycle; memory answers after fw/mw wait cycles.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input logic z);
    int wn;
    o_cycles = 0; o_done = 0; o_inc = 0; o_rw = 0; o_rw_cycle = 0; o_mw = 0; o_mr = 0;
    o_br = 0; o_conflict = 0; o_rw_rd = '0; o_rw_op = '0; o_done_op = '0; o_rw_m2r = 1'b0;
    o_hung = 1'b1; wn = 0; alu_zero = z;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      instr = (mem_req && !MemRead && !MemWrite) ? ins : $urandom;
      if (mem_req) begin
        mem_ready = (wn >= ((MemRead || MemWrite) ? mw : fw));
        wn = mem_ready ? 0 : wn + 1;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
        wn = 0;
      end
      #1;
      o_cycles = c;
      if (pc_inc) o_inc++;
      if (regWrite) begin
        o_rw++; o_rw_cycle = c; o_rw_rd = rd; o_rw_op = AluOp; o_rw_m2r = MemToReg;
      end
      if (MemWrite) o_mw++;
      if (MemRead) o_mr++;
      if (pc_branch) o_br++;
      if (int'(regWrite) + int'(MemWrite) + int'(pc_branch) > 1) o_conflict++;
      if (instr_done) begin o_done++; o_done_op = AluOp; end
      if (instr_done || illegal || mem_fault) begin o_hung = 1'b0; break; end
    end
    o_illegal = illegal;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    n_chk++;
    if (outvec !== '0) begin n_fail++; $display("FAIL reset_outputs got=%h want=0", outvec); end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    n_chk++;
    if ({mem_req, pc_inc, illegal, mem_fault, regWrite} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_first_fetch got=%b want=10000", {mem_req, pc_inc, illegal, mem_fault, regWrite});
    end
    do_reset();
  endtask

  task automatic test_add();
    run_instr(32'h002081B3, 0, 0, 1'b0);
    n_chk++;
    if (o_cycles !== 4 || o_rw_cycle !== 4) begin
      n_fail++; $display("FAIL add_cycles got=%0d/%0d want=4/4", o_cycles, o_rw_cycle);
    end
    n_chk++;
    if ({o_rw_op, o_rw_rd} !== {4'd0, 5'd3}) begin
      n_fail++; $display("FAIL add_wb got op=%0d rd=%0d want op=0 rd=3", o_rw_op, o_rw_rd);
    end
    n_chk++;
    if (o_done !== 1 || o_rw !== 1) begin
      n_fail++; $display("FAIL add_pulses got done=%0d rw=%0d want 1/1", o_done, o_rw);
    end
  endtask

  task automatic test_load_wait();
    run_instr(32'h0080A283, 0, 3, 1'b0);
    n_chk++;
    if (o_cycles !== 8 || o_mr !== 4) begin
      n_fail++; $display("FAIL lw_timing got cyc=%0d rd_cyc=%0d want 8/4", o_cycles, o_mr);
    end
    n_chk++;
    if ({o_rw_m2r, o_rw_rd, o_rw_cycle[3:0]} !== {1'b1, 5'd5, 4'd8}) begin
      n_fail++; $display("FAIL lw_wb got m2r=%b rd=%0d cyc=%0d want 1/5/8", o_rw_m2r, o_rw_rd, o_rw_cycle);
    end
  endtask

  task automatic test_branch();
    for (int z = 0; z < 2; z++) begin
      run_instr(32'h00209463, 0, 0, 1'(z));
      n_chk++;
      if (o_br !== 1 - z || o_inc !== 1 || o_cycles !== 3) begin
        n_fail++;
        $display("FAIL bne_z%0d got br=%0d inc=%0d cyc=%0d want %0d/1/3", z, o_br, o_inc, o_cycles, 1 - z);
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] bad [2] = '{32'h0000007F, 32'h022081B3};
    for (int k = 0; k < 2; k++) begin
      run_instr(bad[k], 0, 0, 1'b0);
      n_chk++;
      if (o_illegal !== 1'b1 || o_cycles !== 3 + k || o_rw !== 0 || o_mw !== 0 || o_done !== 0) begin
        n_fail++;
        $display("FAIL illegal_%0d got ill=%b cyc=%0d rw=%0d mw=%0d want 1/%0d/0/0", k, o_illegal, o_cycles, o_rw, o_mw, 3 + k);
      end
      repeat (3) begin
        @(negedge clk); mem_ready = 1'b1; #1;
        n_chk++;
        if ({illegal, mem_req, regWrite, MemWrite, pc_inc} !== 5'b10000) begin
          n_fail++;
          $display("FAIL illegal_sticky got=%b want=10000", {illegal, mem_req, regWrite, MemWrite, pc_inc});
        end
      end
      do_reset();
    end
    run_instr(32'h002081B3, 1, 0, 1'b0);
    n_chk++;
    if (o_done !== 1 || o_illegal !== 1'b0 || o_cycles !== 5) begin
      n_fail++; $display("FAIL illegal_recover got done=%0d ill=%b cyc=%0d want 1/0/5", o_done, o_illegal, o_cycles);
    end
  endtask

  task automatic test_timeout();
    int req_n = 0, fault_cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk); mem_ready = 1'b0; instr = $urandom; #1;
      if (mem_req) req_n++;
      if (mem_fault) begin fault_cyc = c; break; end
    end
    n_chk++;
    if (req_n !== MEM_TIMEOUT || fault_cyc !== MEM_TIMEOUT + 1) begin
      n_fail++; $display("FAIL timeout got req=%0d fault_at=%0d want %0d/%0d", req_n, fault_cyc, MEM_TIMEOUT, MEM_TIMEOUT + 1);
    end
    repeat (4) begin
      @(negedge clk); mem_ready = 1'b1; #1;
      n_chk++;
      if ({mem_req, pc_inc, regWrite, MemWrite, mem_fault, illegal} !== 6'b000010) begin
        n_fail++;
        $display("FAIL timeout_trap got=%b want=000010", {mem_req, pc_inc, regWrite, MemWrite, mem_fault, illegal});
      end
    end
    do_reset();
  endtask

  task automatic test_reset_in_store();
    int wr_n = 0, done_n = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk); instr = 32'h0020A423; mem_ready = mem_req && !MemWrite; #1;
      if (instr_done) done_n++;
      if (MemWrite) begin wr_n++; if (wr_n == 3) break; end
    end
    @(negedge clk); rst = 1'b1; mem_ready = 1'b1; #1;
    n_chk++;
    if (outvec !== '0) begin n_fail++; $display("FAIL rst_in_store got=%h want=0", outvec); end
    @(posedge clk); #1 rst = 1'b0; mem_ready = 1'b0;
    @(negedge clk); #1;
    if (instr_done) done_n++;
    n_chk++;
    if ({mem_req, MemRead, MemWrite} !== 3'b100 || wr_n !== 3 || done_n !== 0) begin
      n_fail++;
      $display("FAIL store_abort got req/rd/wr=%b waits=%0d done=%0d want 100/3/0", {mem_req, MemRead, MemWrite}, wr_n, done_n);
    end
    do_reset();
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [3:0] op;
    logic legal, taken, z;
    int cls, fw, mw, exp_cyc, sel;
    for (int n = 0; n < 80; n++) begin
      ins = $urandom; cls = $urandom_range(0, 5); sel = $urandom_range(0, 3);
      fw = $urandom_range(0, 4); mw = $urandom_range(0, 4); z = 1'($urandom_range(0, 1));
      case (cls)
        0: ins[6:0] = 7'h33;
        1: ins[6:0] = 7'h13;
        2: ins[6:0] = 7'h03;
        3: ins[6:0] = 7'h23;
        4: ins[6:0] = 7'h63;
        default: do ins[6:0] = 7'($urandom); while (ins[6:0] inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63});
      endcase
      if (sel < 2) ins[31:25] = 7'h00; else if (sel == 2) ins[31:25] = 7'h20;
      if ((cls == 2 || cls == 3) && sel != 3) ins[14:12] = 3'd2;
      model(ins, z, cls, legal, op, taken);
      if (!legal)        exp_cyc = (cls == 5) ? 3 + fw : 4 + fw;
      else if (cls <= 1) exp_cyc = 4 + fw;
      else if (cls == 2) exp_cyc = 5 + fw + mw;
      else if (cls == 3) exp_cyc = 4 + fw + mw;
      else               exp_cyc = 3 + fw;
      run_instr(ins, fw, mw, z);
      n_chk++;
      if (o_hung !== 1'b0 || o_cycles !== exp_cyc || o_illegal !== !legal) begin
        n_fail++;
        $display("FAIL rnd_flow ins=%h got cyc=%0d ill=%b hung=%b want cyc=%0d ill=%b", ins, o_cycles, o_illegal, o_hung, exp_cyc, !legal);
      end
      n_chk++;
      if (o_done !== int'(legal) || o_inc !== 1 || o_conflict !== 0) begin
        n_fail++;
        $display("FAIL rnd_pulses ins=%h got done=%0d inc=%0d conflict=%0d want %0d/1/0", ins, o_done, o_inc, o_conflict, legal);
      end
      n_chk++;
      if (o_rw !== int'(legal && cls <= 2) || (o_rw == 1 && (o_rw_rd !== ins[11:7] || o_rw_cycle !== exp_cyc))) begin
        n_fail++;
        $display("FAIL rnd_wb ins=%h got rw=%0d rd=%0d cyc=%0d want rw=%0d rd=%0d cyc=%0d", ins, o_rw, o_rw_rd, o_rw_cycle, legal && cls <= 2, ins[11:7], exp_cyc);
      end
      n_chk++;
      if (o_rw == 1 && ((cls <= 1 && o_rw_op !== op) || o_rw_m2r !== (cls == 2))) begin
        n_fail++; $display("FAIL rnd_wb_ctl ins=%h got op=%0d m2r=%b want op=%0d m2r=%b", ins, o_rw_op, o_rw_m2r, op, cls == 2);
      end
      n_chk++;
      if (o_mr !== ((legal && cls == 2) ? mw + 1 : 0) || o_mw !== ((legal && cls == 3) ? mw + 1 : 0)) begin
        n_fail++;
        $display("FAIL rnd_mem ins=%h got rd=%0d wr=%0d want %0d/%0d", ins, o_mr, o_mw, (legal && cls == 2) ? mw + 1 : 0, (legal && cls == 3) ? mw + 1 : 0);
      end
      n_chk++;
      if (o_br !== int'(legal && cls == 4 && taken) || (legal && cls == 4 && o_done_op !== op)) begin
        n_fail++;
        $display("FAIL rnd_branch ins=%h z=%b got br=%0d op=%0d want br=%0d op=%0d", ins, z, o_br, o_done_op, legal && cls == 4 && taken, op);
      end
      if (!legal || o_hung) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_wait();
    test_branch();
    test_illegal();
    test_timeout();
    test_reset_in_store();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
